// File: rtl/sram_bus_responder.sv
// sram_bus_responder: device end of the SRAM-style shared data bus.
// Decodes active-low strobes, stores writes, drives registered read data.
`timescale 1ns/1ps
module sram_bus_responder #(
    parameter int N      = 16,
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CE_N,
    input  logic              OE_N,
    input  logic              WE_N,
    input  logic              UB_N,
    input  logic              LB_N,
    input  logic [ADDR_W-1:0] ADDR,
    inout  wire  [N-1:0]      Data,
    output logic [15:0]       ReadCount,
    output logic [15:0]       WriteCount,
    output logic              Conflict
);

    localparam int H     = N / 2;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_conflict;
    logic [N-1:0] r_rd;
    logic [1:0]  r_lane;
    logic [15:0] r_rcnt;
    logic [15:0] r_wcnt;
    logic        r_conflict;
    logic [N-1:0] r_mem [DEPTH];
    logic        w_drv_hi;
    logic        w_drv_lo;

    // Decode the strobes sampled at this edge; write wins over output enable.
    always_comb begin
        w_next     = S_IDLE;
        w_conflict = 1'b0;
        if (!CE_N) begin
            if (!WE_N) begin
                w_next     = S_WRITE;
                w_conflict = !OE_N;
            end else if (!OE_N) begin
                w_next = S_READ;
            end
        end
    end

    // State, counters, conflict flag and the read/lane capture registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_rd       <= '0;
            r_lane     <= '0;
            r_rcnt     <= '0;
            r_wcnt     <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_conflict <= w_conflict;
            if (w_next == S_WRITE) begin
                r_wcnt <= r_wcnt + 16'd1;
            end
            if (w_next == S_READ) begin
                r_rcnt <= r_rcnt + 16'd1;
                r_rd   <= r_mem[ADDR];
                r_lane <= {~UB_N, ~LB_N};
            end
        end
    end

    // Storage is never reset; lanes are written independently.
    always_ff @(posedge Clk) begin
        if (!Reset && w_next == S_WRITE) begin
            if (!UB_N) begin
                r_mem[ADDR][N-1:H] <= Data[N-1:H];
            end
            if (!LB_N) begin
                r_mem[ADDR][H-1:0] <= Data[H-1:0];
            end
        end
    end

    assign w_drv_hi = (r_state == S_READ) && r_lane[1];
    assign w_drv_lo = (r_state == S_READ) && r_lane[0];

    assign Data[N-1:H] = w_drv_hi ? r_rd[N-1:H] : {(N-H){1'bz}};
    assign Data[H-1:0] = w_drv_lo ? r_rd[H-1:0] : {H{1'bz}};

    assign ReadCount  = r_rcnt;
    assign WriteCount = r_wcnt;
    assign Conflict   = r_conflict;

endmodule

// File: tb/tb_sram_bus_responder.sv
// tb_sram_bus_responder: directed and random bus cycles against a
// lane-level memory model; a floating bus reads back as all ones.
`timescale 1ns/1ps
module tb_sram_bus_responder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        CE_N = 1'b1;
    logic        OE_N = 1'b1;
    logic        WE_N = 1'b1;
    logic        UB_N = 1'b1;
    logic        LB_N = 1'b1;
    logic [7:0]  ADDR = '0;
    tri1  [15:0] Data;
    logic [15:0] ReadCount;
    logic [15:0] WriteCount;
    logic        Conflict;

    logic        tb_en = 1'b0;
    logic [15:0] tb_drv = '0;

    assign Data = tb_en ? tb_drv : 16'hzzzz;

    sram_bus_responder #(.N(16), .ADDR_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N),
        .UB_N(UB_N), .LB_N(LB_N), .ADDR(ADDR), .Data(Data),
        .ReadCount(ReadCount), .WriteCount(WriteCount), .Conflict(Conflict)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];
    bit          vu [256];
    bit          vl [256];
    logic [15:0] rc = '0;
    logic [15:0] wc = '0;
    bit          was_read = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at negedge, check just after the sampling edge.
    task automatic step(input bit ce, input bit oe, input bit we,
                        input bit ub, input bit lb,
                        input logic [7:0] a, input logic [15:0] d);
        logic [15:0] exp_d;
        logic [15:0] mask;
        logic        exp_c;
        @(negedge Clk);
        CE_N = ce; OE_N = oe; WE_N = we; UB_N = ub; LB_N = lb; ADDR = a;
        tb_en = !ce && !we;
        tb_drv = d;
        @(posedge Clk);
        #1;
        exp_d = 16'hFFFF;
        mask  = 16'hFFFF;
        exp_c = 1'b0;
        if (!ce && !we) begin
            if (!ub) begin mem[a][15:8] = d[15:8]; vu[a] = 1'b1; end
            if (!lb) begin mem[a][7:0] = d[7:0]; vl[a] = 1'b1; end
            wc++;
            exp_c = !oe;
            exp_d = d;
        end else if (!ce && !oe) begin
            rc++;
            if (!ub) begin
                exp_d[15:8] = mem[a][15:8];
                if (!vu[a]) mask[15:8] = 8'h00;
            end
            if (!lb) begin
                exp_d[7:0] = mem[a][7:0];
                if (!vl[a]) mask[7:0] = 8'h00;
            end
        end
        was_read = !ce && we && !oe;
        chk("data", Data & mask, exp_d & mask);
        chk("readcount", ReadCount, rc);
        chk("writecount", WriteCount, wc);
        chk("conflict", {15'd0, Conflict}, {15'd0, exp_c});
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d,
                      input bit ub, input bit lb);
        step(1'b0, 1'b1, 1'b0, ub, lb, a, d);
    endtask

    task automatic rd(input logic [7:0] a, input bit ub, input bit lb);
        step(1'b0, 1'b0, 1'b1, ub, lb, a, 16'h0000);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 16'h0000);
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rc_keep;
        logic [15:0] wc_keep;
        for (int i = 0; i < 256; i++) begin
            vu[i] = 1'b0;
            vl[i] = 1'b0;
            mem[i] = '0;
        end

        repeat (3) @(posedge Clk);
        #1;
        chk("rst_data", Data, 16'hFFFF);
        chk("rst_rc", ReadCount, 16'h0000);
        chk("rst_wc", WriteCount, 16'h0000);
        chk("rst_conf", {15'd0, Conflict}, 16'h0000);
        @(negedge Clk);
        Reset = 1'b0;

        wr(8'h05, 16'h1234, 1'b0, 1'b0);
        rd(8'h05, 1'b0, 1'b0);
        idle();

        wr(8'h10, 16'hAABB, 1'b0, 1'b0);
        wr(8'h10, 16'hCCDD, 1'b1, 1'b0);
        rd(8'h10, 1'b0, 1'b0);
        rd(8'h10, 1'b0, 1'b1);
        idle();

        for (int i = 0; i < 4; i++) wr(8'(i), 16'(i + 1), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) rd(8'(i), 1'b0, 1'b0);
        idle();

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 16'h5A5A);
        idle();
        rd(8'h20, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h21, 16'h1111);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 16'h2222);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 16'h0000);

        for (int i = 0; i < 400; i++) begin
            int k;
            logic [7:0] a;
            k = $urandom_range(0, 5);
            a = 8'h80 + 8'($urandom_range(0, 15));
            case (k)
                0: idle();
                1, 2: begin
                    if (was_read) idle();
                    step(1'b0, 1'($urandom_range(0, 3) != 0), 1'b0,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         a, 16'($urandom));
                end
                3, 4: rd(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                default: step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, a, 16'h0000);
            endcase
        end
        idle();

        wr(8'h30, 16'hBEEF, 1'b0, 1'b0);
        rd(8'h30, 1'b0, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        rc = '0;
        wc = '0;
        chk("midrd_data", Data, 16'hFFFF);
        chk("midrd_rc", ReadCount, 16'h0000);
        chk("midrd_wc", WriteCount, 16'h0000);
        chk("midrd_conf", {15'd0, Conflict}, 16'h0000);
        @(negedge Clk);
        CE_N = 1'b1;
        OE_N = 1'b1;
        Reset = 1'b0;
        idle();
        rd(8'h30, 1'b0, 1'b0);
        wr(8'h31, 16'h0F0F, 1'b0, 1'b0);
        wr(8'h32, 16'h0F0F, 1'b0, 1'b0);
        idle();

        rc_keep = rc;
        wc_keep = wc;
        @(negedge Clk);
        CE_N = 1'b0; OE_N = 1'b0; WE_N = 1'b1;
        UB_N = 1'b0; LB_N = 1'b0; ADDR = 8'h30;
        repeat (65536) @(posedge Clk);
        @(negedge Clk);
        CE_N = 1'b1; OE_N = 1'b1;
        @(posedge Clk);
        #1;
        chk("wrap_rc", ReadCount, rc_keep);
        chk("wrap_wc", WriteCount, wc_keep);
        chk("wrap_data", Data, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
